// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: round-robin writeback arbiter feeding one regfile write port.
// Define REGFILE_WB_ARB_FWD_EN to enable write-to-read forwarding of the registered beat.
package core_cfg;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int XLEN = 64;
endpackage

module regfile_wb_arb #(
    parameter int ADDR_WIDTH = core_cfg::REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = core_cfg::XLEN,
    parameter int NUM_REQ = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             wb_stall,
    output logic [ADDR_WIDTH-1:0]            waddr,
    output logic [DATA_WIDTH-1:0]            wdata,
    output logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            raddr1,
    input  logic [ADDR_WIDTH-1:0]            raddr2,
    output logic                             fwd_hit1,
    output logic                             fwd_hit2,
    output logic [DATA_WIDTH-1:0]            fwd_data1,
    output logic [DATA_WIDTH-1:0]            fwd_data2
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         gnt_idx;
    logic                  gnt_any;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Walk downward from the farthest offset so the nearest valid index at/after rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready = (gnt_any && !wb_stall && rst_n) ? NUM_REQ'(1) << gnt_idx : '0;
    assign xfer      = |req_ready;
    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data  = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wen    <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            wen <= xfer && sel_addr != '0;
            if (xfer) begin
                waddr  <= sel_addr;
                wdata  <= sel_data;
                rr_ptr <= gnt_idx == PW'(NUM_REQ - 1) ? '0 : gnt_idx + PW'(1);
            end
        end
    end

`ifdef REGFILE_WB_ARB_FWD_EN
    assign fwd_hit1  = wen && raddr1 == waddr && raddr1 != '0;
    assign fwd_hit2  = wen && raddr2 == waddr && raddr2 != '0;
    assign fwd_data1 = fwd_hit1 ? wdata : '0;
    assign fwd_data2 = fwd_hit2 ? wdata : '0;
`else
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb: directed self-checking bench for regfile_wb_arb (NUM_REQ=4, XLEN=64).
module tb_regfile_wb_arb;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            wb_stall;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic            wen;
    logic [AW-1:0]   raddr1, raddr2;
    logic            fwd_hit1, fwd_hit2;
    logic [DW-1:0]   fwd_data1, fwd_data2;

    int n_checks = 0;
    int n_fail = 0;

    regfile_wb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
        .waddr(waddr), .wdata(wdata), .wen(wen), .raddr1(raddr1), .raddr2(raddr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '1;
        wb_stall = 1'b0;
        raddr1 = '0;
        raddr2 = '0;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) set_req(i, AW'(8 + i), 64'hA0 + 64'(i));
        tick();
        tick();
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_wen", 64'(wen), 64'h0);
        check("rst_waddr", 64'(waddr), 64'h0);
        check("rst_wdata", wdata, 64'h0);

        // round robin with all four valid
        rst_n = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            check($sformatf("rr_ready%0d", n), 64'(req_ready), 64'(4'b0001 << (n % 4)));
            tick();
            check($sformatf("rr_wen%0d", n), 64'(wen), 64'h1);
            check($sformatf("rr_waddr%0d", n), 64'(waddr), 64'(8 + n % 4));
            check($sformatf("rr_wdata%0d", n), wdata, 64'hA0 + 64'(n % 4));
        end

        // sparse: only req 2, rr_ptr currently 1
        req_valid = 4'b0100;
        set_req(2, 5'd5, 64'hDEAD);
        #1;
        check("sp_ready", 64'(req_ready), 64'h4);
        tick();
        check("sp_wen", 64'(wen), 64'h1);
        check("sp_waddr", 64'(waddr), 64'h5);
        check("sp_wdata", wdata, 64'hDEAD);
        req_valid = 4'b0000;
        tick();
        check("idle_wen", 64'(wen), 64'h0);
        check("idle_waddr_hold", 64'(waddr), 64'h5);
        check("idle_wdata_hold", wdata, 64'hDEAD);
        req_valid = 4'b1001;
        #1;
        check("sp_rrptr3", 64'(req_ready), 64'h8);

        // x0 drop: req 1 with addr 0
        req_valid = 4'b0010;
        set_req(1, 5'd0, 64'h55);
        #1;
        check("x0_ready", 64'(req_ready), 64'h2);
        tick();
        check("x0_wen", 64'(wen), 64'h0);
        req_valid = 4'b1111;
        #1;
        check("x0_rrptr2", 64'(req_ready), 64'h4);
        req_valid = 4'b0000;
        tick();

        // stall with req 0 valid; rr_ptr is 2
        wb_stall = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 5'd8, 64'hA0);
        for (int n = 0; n < 3; n++) begin
            #1;
            check($sformatf("st_ready%0d", n), 64'(req_ready), 64'h0);
            tick();
            check($sformatf("st_wen%0d", n), 64'(wen), 64'h0);
        end
        wb_stall = 1'b0;
        #1;
        check("st_release_ready", 64'(req_ready), 64'h1);
        tick();
        wb_stall = 1'b1;
        #1;
        check("st_beat_wen", 64'(wen), 64'h1);
        check("st_beat_waddr", 64'(waddr), 64'h8);
        wb_stall = 1'b0;

        // forwarding
        set_req(0, 5'd7, 64'h1234);
        tick();
        req_valid = 4'b0000;
        raddr1 = 5'd7;
        raddr2 = 5'd0;
        #1;
        check("fw_wen", 64'(wen), 64'h1);
`ifdef REGFILE_WB_ARB_FWD_EN
        check("fw_hit1", 64'(fwd_hit1), 64'h1);
        check("fw_data1", fwd_data1, 64'h1234);
        check("fw_hit2", 64'(fwd_hit2), 64'h0);
        check("fw_data2", fwd_data2, 64'h0);
        raddr2 = 5'd7;
        #1;
        check("fw_hit2_match", 64'(fwd_hit2), 64'h1);
`else
        check("fw_hit1", 64'(fwd_hit1), 64'h0);
        check("fw_data1", fwd_data1, 64'h0);
        check("fw_hit2", 64'(fwd_hit2), 64'h0);
        check("fw_data2", fwd_data2, 64'h0);
`endif
        raddr1 = '0;
        raddr2 = '0;
        tick();

        // reset asserted mid-cycle while a grant is live
        req_valid = 4'b1111;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_ready", 64'(req_ready), 64'h0);
        check("mr_wen", 64'(wen), 64'h0);
        check("mr_waddr", 64'(waddr), 64'h0);
        tick();
        req_valid = 4'b0000;
        rst_n = 1'b1;
        tick();
        check("mr_no_write", 64'(wen), 64'h0);
        req_valid = 4'b1111;
        #1;
        check("mr_first_grant", 64'(req_ready), 64'h1);
        tick();
        check("mr_first_waddr", 64'(waddr), 64'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default core_cfg.REG_ADDR_WIDTH, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default core_cfg.XLEN, write data width.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of writeback requesters (range 2..8).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  packed destination indices; requester i at slice i.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed write data; requester i at slice i.
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-hot grant; a beat transfers when valid and ready are both high.
REQ-010 SHALL have port wb_stall  input  1  when high, no grants are issued.
REQ-011 SHALL have port waddr  output  ADDR_WIDTH  regfile write index.
REQ-012 SHALL have port wdata  output  DATA_WIDTH  regfile write data.
REQ-013 SHALL have port wen  output  1  regfile write enable.
REQ-014 SHALL have port raddr1, raddr2  input  ADDR_WIDTH each  regfile read indices, used for forwarding.
REQ-015 SHALL have port fwd_hit1, fwd_hit2  output  1 each  forward-valid flags.
REQ-016 SHALL have port fwd_data1, fwd_data2  output  DATA_WIDTH each  forwarded data.

Function
REQ-017 SHALL compute req_ready combinationally: zero when wb_stall=1 or no req_valid; otherwise one-hot on the first valid index at or after rr_ptr, searching upward and wrapping at NUM_REQ-1 to 0.
REQ-018 SHALL drive at most one req_ready bit per cycle and SHALL NOT assert req_ready[i] unless req_valid[i]=1.
REQ-019 SHALL, on a transfer from requester g, set rr_ptr to (g+1) mod NUM_REQ at the next edge; rr_ptr SHALL otherwise hold.
REQ-020 SHALL register the granted beat: waddr/wdata take the granted slice, and wen=1 in the cycle after the transfer (latency 1).
REQ-021 SHALL accept writes to index 0 (ready asserted, rr_ptr advanced) but SHALL hold wen=0 for them.
REQ-022 SHALL deassert wen in any cycle that follows a cycle with no transfer; waddr/wdata SHALL hold their last values.
REQ-023 SHALL sustain one transfer per cycle with no bubbles when wb_stall=0 and any req_valid is high.
REQ-024 SHALL keep req_ready independent of req_addr/req_data (no combinational path from data to ready).
REQ-025 SHALL NOT let wb_stall affect a beat already registered; that beat's wen still asserts.

Reset
REQ-026 SHALL, while rst_n=0, force wen=0, waddr=0, wdata=0, rr_ptr=0, and req_ready=0, asynchronously.
REQ-027 SHALL discard any beat granted in the cycle rst_n falls; no write SHALL issue after reset release for it.
REQ-028 SHALL issue the first grant after release from rr_ptr=0.

Configuration
REQ-029 SHALL honour macro REGFILE_WB_ARB_FWD_EN.
REQ-030 With REGFILE_WB_ARB_FWD_EN defined: fwd_hitN SHALL be wen && raddrN==waddr && raddrN!=0 (combinational); fwd_dataN SHALL be wdata when hit, else 0.
REQ-031 Without REGFILE_WB_ARB_FWD_EN: fwd_hit1/2 and fwd_data1/2 SHALL be tied to 0; the ports SHALL remain present.

Verification
REQ-032 The bench SHALL cover these cases (NUM_REQ=4, XLEN=64):
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, wen=0; first grant after release goes to requester 0.
- Round-robin: all four requesters valid continuously -> grant order 0,1,2,3,0; one wen per cycle from the second cycle onward.
- Sparse: only req 2 valid, addr=5, data=0xDEAD -> next cycle wen=1, waddr=5, wdata=0xDEAD; rr_ptr=3.
- x0 drop: req 1 valid, addr=0 -> req_ready[1]=1; next cycle wen=0; rr_ptr=2.
- Stall: wb_stall=1 with req 0 valid -> req_ready=0 for every stalled cycle; grant in the first cycle wb_stall=0.
- Forward (macro on): beat addr=7, data=0x1234 registered, raddr1=7 -> fwd_hit1=1, fwd_data1=0x1234. raddr2=0 -> fwd_hit2=0. Macro off: all fwd outputs 0.
